// File: rtl/id_pipe_stage.sv
// RV instruction decode stage with a small FIFO of decoded entries.
// Optional CSR decode is enabled by defining ID_PIPE_CSR_EN.
module id_pipe_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [XLEN-1:0] out_imm,
  output logic [3:0]      out_alu_op,
  output logic [9:0]      out_ctrl,
  output logic            out_illegal
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
`ifdef ID_PIPE_CSR_EN
  localparam logic [6:0] OPC_CSR    = 7'b1110011;
`endif
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_op;
    logic [9:0]      ctrl;
    logic            illegal;
  } entry_t;

  entry_t [BUF_DEPTH-1:0] buf_q;
  logic   [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic   [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic   [CNT_W-1:0]     count_q, count_d;
  logic                   ready_en_q;
  logic                   push_c, pop_c;
  entry_t                 dec_c;
  entry_t                 head_c;

  logic [6:0]      opcode_c;
  logic [2:0]      funct3_c;
  logic [XLEN-1:0] imm_i_c, imm_s_c, imm_b_c, imm_u_c, imm_j_c, imm_sh_c;

  assign opcode_c = in_inst[6:0];
  assign funct3_c = in_inst[14:12];

  // Immediate formats, sign-extended from inst[31] by signed width casts
  assign imm_i_c  = XLEN'($signed(in_inst[31:20]));
  assign imm_s_c  = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_b_c  = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                   in_inst[11:8], 1'b0}));
  assign imm_u_c  = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign imm_j_c  = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                   in_inst[30:21], 1'b0}));
  assign imm_sh_c = (XLEN == 64) ? XLEN'(in_inst[25:20]) : XLEN'(in_inst[24:20]);

  // Combinational decode of the offered instruction
  always_comb begin
    dec_c        = '0;
    dec_c.pc     = in_pc;
    dec_c.rs1    = in_inst[19:15];
    dec_c.rs2    = in_inst[24:20];
    dec_c.rd     = in_inst[11:7];
    dec_c.funct3 = funct3_c;
    case (opcode_c)
      OPC_R: begin
        dec_c.ctrl[0] = 1'b1;
        dec_c.alu_op  = {in_inst[30], funct3_c};
      end
      OPC_OPIMM: begin
        dec_c.ctrl[1] = 1'b1;
        if (funct3_c == 3'b001 || funct3_c == 3'b101) begin
          dec_c.imm = imm_sh_c;
        end else begin
          dec_c.imm = imm_i_c;
        end
        if (funct3_c == 3'b101) begin
          dec_c.alu_op = {in_inst[30], funct3_c};
        end else begin
          dec_c.alu_op = {1'b0, funct3_c};
        end
      end
      OPC_LOAD: begin
        dec_c.ctrl[2] = 1'b1;
        dec_c.imm     = imm_i_c;
      end
      OPC_LUI: begin
        dec_c.ctrl[3] = 1'b1;
        dec_c.imm     = imm_u_c;
      end
      OPC_STORE: begin
        dec_c.ctrl[4] = 1'b1;
        dec_c.imm     = imm_s_c;
      end
      OPC_BRANCH: begin
        dec_c.ctrl[5] = 1'b1;
        dec_c.imm     = imm_b_c;
      end
      OPC_JAL: begin
        dec_c.ctrl[6] = 1'b1;
        dec_c.imm     = imm_j_c;
      end
      OPC_JALR: begin
        dec_c.ctrl[7] = 1'b1;
        dec_c.imm     = imm_i_c;
      end
`ifdef ID_PIPE_CSR_EN
      OPC_CSR: begin
        dec_c.ctrl[8] = 1'b1;
        dec_c.imm     = XLEN'(in_inst[19:15]);
      end
`endif
      OPC_AUIPC: begin
        dec_c.ctrl[9] = 1'b1;
        dec_c.imm     = imm_u_c;
      end
      default: begin
        dec_c.illegal = 1'b1;
      end
    endcase
  end

  // Handshakes; in_ready depends only on state and flush, never out_ready
  assign in_ready  = ready_en_q && (count_q < CNT_W'(BUF_DEPTH)) && !flush;
  assign out_valid = (count_q != '0);
  assign push_c    = in_valid && in_ready;
  assign pop_c     = out_valid && out_ready;

  // Pointer and occupancy next-state; flush overrides push and pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push_c && !pop_c) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop_c && !push_c) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_en_q <= 1'b1;
    end
  end

  // Entry storage; cleared on reset so the idle head reads as all zeros
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
    end else if (push_c) begin
      buf_q[wr_ptr_q] <= dec_c;
    end
  end

  assign head_c      = buf_q[rd_ptr_q];
  assign out_pc      = head_c.pc;
  assign out_rs1     = head_c.rs1;
  assign out_rs2     = head_c.rs2;
  assign out_rd      = head_c.rd;
  assign out_funct3  = head_c.funct3;
  assign out_imm     = head_c.imm;
  assign out_alu_op  = head_c.alu_op;
  assign out_ctrl    = head_c.ctrl;
  assign out_illegal = head_c.illegal;

endmodule

// File: tb/tb_id_pipe_stage.sv
// Randomized and directed bench for id_pipe_stage (XLEN=32, BUF_DEPTH=2)
// against a queue-based behavioural model of the decode stage.
module tb_id_pipe_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rs1, out_rs2, out_rd;
  logic [2:0]      out_funct3;
  logic [XLEN-1:0] out_imm;
  logic [3:0]      out_alu_op;
  logic [9:0]      out_ctrl;
  logic            out_illegal;

  id_pipe_stage #(.XLEN(XLEN), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_funct3(out_funct3), .out_imm(out_imm),
    .out_alu_op(out_alu_op), .out_ctrl(out_ctrl), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [9:0]  ctrl;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];
  bit   alive;
  int   tests = 0;
  int   fails = 0;

  // Reference decode straight from the instruction-set rules
  function automatic exp_t ref_dec(input logic [31:0] i);
    exp_t e;
    int   s;
    logic [2:0] f3;
    e = '0;
    s = $signed(i);
    f3 = i[14:12];
    e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7]; e.f3 = f3;
    case (i[6:0])
      7'h33: begin e.ctrl = 10'd1; e.alu = {i[30], f3}; end
      7'h13: begin
        e.ctrl = 10'd1 << 1;
        e.imm  = (f3 == 3'd1 || f3 == 3'd5) ? 32'(i[24:20]) : 32'(s >>> 20);
        e.alu  = (f3 == 3'd5) ? {i[30], f3} : {1'b0, f3};
      end
      7'h03: begin e.ctrl = 10'd1 << 2; e.imm = 32'(s >>> 20); end
      7'h37: begin e.ctrl = 10'd1 << 3; e.imm = i & 32'hFFFF_F000; end
      7'h23: begin e.ctrl = 10'd1 << 4; e.imm = 32'((s >>> 25) * 32) | 32'(i[11:7]); end
      7'h63: begin
        e.ctrl = 10'd1 << 5;
        e.imm  = 32'((s >>> 31) * 4096) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
      end
      7'h6F: begin
        e.ctrl = 10'd1 << 6;
        e.imm  = 32'((s >>> 31) * 1048576) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
      end
      7'h67: begin e.ctrl = 10'd1 << 7; e.imm = 32'(s >>> 20); end
`ifdef ID_PIPE_CSR_EN
      7'h73: begin e.ctrl = 10'd1 << 8; e.imm = 32'(i[19:15]); end
`endif
      7'h17: begin e.ctrl = 10'd1 << 9; e.imm = i & 32'hFFFF_F000; end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model head
  task automatic check_outputs();
    exp_t e;
    cmp("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      e = ref_dec(q[0].inst);
      cmp("out_pc", 64'(out_pc), 64'(q[0].pc));
      cmp("out_rs1", 64'(out_rs1), 64'(e.rs1));
      cmp("out_rs2", 64'(out_rs2), 64'(e.rs2));
      cmp("out_rd", 64'(out_rd), 64'(e.rd));
      cmp("out_funct3", 64'(out_funct3), 64'(e.f3));
      cmp("out_imm", 64'(out_imm), 64'(e.imm));
      cmp("out_alu_op", 64'(out_alu_op), 64'(e.alu));
      cmp("out_ctrl", 64'(out_ctrl), 64'(e.ctrl));
      cmp("out_illegal", 64'(out_illegal), 64'(e.ill));
    end
  endtask

  // One clock: drive at negedge, update model at posedge, check at next negedge
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic fl, input logic ordy);
    bit rdy;
    bit pop;
    in_valid = v; in_inst = inst; in_pc = pc; flush = fl; out_ready = ordy;
    #1;
    rdy = alive && (q.size() < DEPTH) && !fl;
    cmp("in_ready", 64'(in_ready), 64'(rdy));
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      pop = (q.size() != 0) && ordy;
      if (pop) void'(q.pop_front());
      if (v && rdy) q.push_back('{inst: inst, pc: pc});
    end
    alive = 1'b1;
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [11];
    logic [31:0] r;
    ops = '{7'h33, 7'h13, 7'h03, 7'h37, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h73, 7'h17, 7'h00};
    r = $urandom();
    r[6:0] = ops[$urandom_range(0, 10)];
    if ($urandom_range(0, 10) == 0) r[6:0] = 7'($urandom());
    return r;
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    alive = 1'b0;
    #2;
    cmp("rst_in_ready", 64'(in_ready), 64'd0);
    cmp("rst_out_valid", 64'(out_valid), 64'd0);
    cmp("rst_fields", {out_pc, out_imm}, 64'd0);
    cmp("rst_ctrl", {out_ctrl, out_alu_op, out_illegal, out_rd, out_rs1, out_rs2, out_funct3}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // addi x1,x2,-1
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'hFFF10093, 32'h1000, 1'b0, 1'b1);
    cmp("addi_valid", 64'(out_valid), 64'd1);
    cmp("addi_ctrl", 64'(out_ctrl), 64'h2);
    cmp("addi_rs1_rd", {out_rs1, out_rd}, {5'd2, 5'd1});
    cmp("addi_imm", 64'(out_imm), 64'hFFFF_FFFF);
    cmp("addi_alu", 64'(out_alu_op), 64'h0);
    // srai x3,x4,5
    step(1'b1, 32'h40525193, 32'h1004, 1'b0, 1'b1);
    cmp("srai_alu", 64'(out_alu_op), 64'hD);
    cmp("srai_imm", 64'(out_imm), 64'd5);
    cmp("srai_rs1_rd", {out_rs1, out_rd}, {5'd4, 5'd3});
    // csrrw x0,mscratch,x2
    step(1'b1, 32'h34011073, 32'h1008, 1'b0, 1'b1);
`ifdef ID_PIPE_CSR_EN
    cmp("csr_ctrl", 64'(out_ctrl), 64'h100);
    cmp("csr_imm", 64'(out_imm), 64'd2);
    cmp("csr_ill", 64'(out_illegal), 64'd0);
`else
    cmp("csr_ill", 64'(out_illegal), 64'd1);
    cmp("csr_ctrl", 64'(out_ctrl), 64'h0);
`endif
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Backpressure: three offers into a two-deep buffer
    step(1'b1, 32'h00000013, 32'h100, 1'b0, 1'b0);
    step(1'b1, 32'h00000013, 32'h104, 1'b0, 1'b0);
    step(1'b1, 32'h00000013, 32'h108, 1'b0, 1'b0);
    cmp("full_in_ready", 64'(in_ready), 64'd0);
    cmp("full_head_pc", 64'(out_pc), 64'h100);
    step(1'b1, 32'h00000013, 32'h108, 1'b0, 1'b1);
    cmp("pop1_head_pc", 64'(out_pc), 64'h104);
    step(1'b1, 32'h00000013, 32'h108, 1'b0, 1'b1);
    cmp("pop2_head_pc", 64'(out_pc), 64'h108);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cmp("drained", 64'(out_valid), 64'd0);

    // Flush while full with an offer pending
    step(1'b1, 32'h00000013, 32'h200, 1'b0, 1'b0);
    step(1'b1, 32'h00000013, 32'h204, 1'b0, 1'b0);
    step(1'b1, 32'h00000013, 32'hDEAD, 1'b1, 1'b0);
    cmp("flush_valid", 64'(out_valid), 64'd0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cmp("flush_stays_empty", 64'(out_valid), 64'd0);

    // Reset with one stale entry buffered
    step(1'b1, 32'h00000013, 32'h300, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    cmp("mid_rst_valid", 64'(out_valid), 64'd0);
    cmp("mid_rst_in_ready", 64'(in_ready), 64'd0);
    cmp("mid_rst_pc", 64'(out_pc), 64'd0);
    q.delete();
    alive = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'h00500113, 32'h400, 1'b0, 1'b0);
    step(1'b1, 32'h00500113, 32'h404, 1'b0, 1'b0);
    cmp("post_rst_pc", 64'(out_pc), 64'h404);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cmp("post_rst_empty", 64'(out_valid), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 3) != 0, rand_inst(), $urandom(),
           $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
